request_unit: RTL and testbench
===============================

# request_unit

Memory request unit between the single-port instruction/data RAM and the single-cycle core datapath. It serialises each instruction into an instruction fetch, an optional data load/store, and a commit. It holds the fetched instruction stable for the control decoder and produces the `i_ready` pulse that advances the PC. It replaces the core's direct dual-port RAM access when the design targets a single-port RAM with fixed access latency.

## Interface
- `RAM_LATENCY`, default 2: cycles a RAM request must be held before `ramload` is valid (legal range ≥1).
- `clk` in 1: system clock; all state updates on rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `imemaddr` in 32: instruction address (PC).
- `dmmaddr` in 32: data address (ALU result).
- `dmmstore` in 32: store data (rs2 value).
- `d_read_req` in 1: decoded memRead for the currently held instruction.
- `d_write_req` in 1: decoded memWrite for the currently held instruction.
- `ramload` in 32: RAM read data.
- `imemload` out 32: held instruction word for the decoder.
- `dmmload` out 32: held load data for register writeback.
- `i_ready` out 1: one-cycle commit pulse; PC advance and register write enable.
- `d_ready` out 1: one-cycle pulse coincident with `i_ready` when a data access was performed.
- `ramaddr` out 32, `ramstore` out 32, `Ren` out 1, `Wen` out 1: RAM request.

## Operation
- FSM states: IDLE, FETCH, DECODE, DATA, COMMIT.
- IDLE: reset state; no request; goes to FETCH on the next edge.
- FETCH: `Ren`=1, `ramaddr`={`imemaddr`[31:2],2'b00}. Held for exactly `RAM_LATENCY` cycles. At the edge ending the last cycle, `imemload`←`ramload`, then go to DECODE.
- DECODE: one cycle with no request. Sample `d_write_req`/`d_read_req`.
  - Write → DATA (write). Read → DATA (read). Neither → COMMIT.
  - Both asserted: write takes priority; the read is dropped.
- DATA: `ramaddr`={`dmmaddr`[31:2],2'b00}. Held for `RAM_LATENCY` cycles.
  - Write: `Wen`=1, `Ren`=0, `ramstore`=`dmmstore`.
  - Read: `Ren`=1. `dmmload`←`ramload` at the final edge.
  - Then go to COMMIT.
- COMMIT: `i_ready`=1 for one cycle. `d_ready`=1 if DATA was visited for this instruction. Then go to FETCH.
- `ramaddr`/`ramstore`/`Ren`/`Wen` are combinational from state and inputs. `ramaddr`=0, `ramstore`=0, `Ren`=`Wen`=0 outside FETCH/DATA. Inputs are stable during a request because the PC and register file change only on `i_ready`.
- `imemload` and `dmmload` change only at their capture edges and otherwise hold their values through COMMIT.
- A latency counter clears on every state entry and is `$clog2(RAM_LATENCY+1)` bits wide. It never wraps inside a state.

## Timing
- Reset values (asynchronous, immediate): state IDLE, counter 0, `imemload`=32'h0000_0013 (NOP), `dmmload`=0, `i_ready`=`d_ready`=0, `Ren`=`Wen`=0, `ramaddr`=`ramstore`=0.
- Reset asserted mid-FETCH/DATA: request drops in the same cycle. A partial write is the RAM's concern; no commit occurs.
- First `Ren` appears in the second cycle after `nRST` deasserts (IDLE occupies the first).
- Instruction latency, FETCH entry to end of COMMIT:
  - No data access: `RAM_LATENCY`+2 cycles.
  - Load/store: 2·`RAM_LATENCY`+2 cycles.
- Back-to-back instructions: COMMIT is followed directly by FETCH at the new PC. There are no idle cycles between instructions.
- `i_ready` and `d_ready` are never high for two consecutive cycles.

## Structure
- Shared package `request_pkg`:
  - `req_state_t` enum (IDLE, FETCH, DECODE, DATA, COMMIT).
  - `NOP_INSTR` constant.
  - `WORD_MASK` constant.
- Sub-module `latency_counter`: parameter `MAX`; inputs `clk`, `nRST`, `clear`; output `done`, high on the last cycle of a `MAX`-cycle hold.
- FSM, capture registers and RAM output mux live in `request_unit`.

## Test plan
- Reset then release, `RAM_LATENCY`=2, `imemaddr`=0x0, `ramload`=0x00500093:
  - `Ren`=1 on cycles 2–3 with `ramaddr`=0.
  - `imemload`=0x00500093 after cycle 3.
  - `i_ready` pulses on cycle 5; `d_ready`=0.
- Load, `dmmaddr`=0x46 (unaligned), `ramload`=0xDEADBEEF during DATA:
  - `ramaddr`=0x44 in DATA.
  - `dmmload`=0xDEADBEEF.
  - `i_ready` and `d_ready` both high on cycle 2·2+2 after FETCH entry.
- Store, `dmmaddr`=0x100, `dmmstore`=0x12345678:
  - `Wen`=1 for exactly 2 cycles with `ramstore`=0x12345678 and `Ren`=0.
  - `dmmload` unchanged.
- `d_read_req` and `d_write_req` both high: store performed only; `Ren` stays 0 throughout DATA.
- `nRST` pulsed low in the second DATA cycle:
  - `Wen` drops immediately; no `i_ready`.
  - `imemload` returns to 0x00000013.
  - Fetch restarts from IDLE.
- `RAM_LATENCY`=1, back-to-back non-memory instructions: `i_ready` every 3 cycles, `Ren` high in every FETCH cycle.

Source files
------------

// File: rtl/request_pkg.sv
// rtl/request_pkg.sv - shared types and constants for the memory request unit
package request_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        DATA,
        COMMIT
    } req_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/request_unit_latency_counter.sv
// rtl/request_unit_latency_counter.sv - fixed-latency hold counter, done on the last hold cycle
module latency_counter #(
    parameter int MAX = 2
) (
    input  logic clk,
    input  logic nRST,
    input  logic clear,
    output logic done
);

    localparam int CW = $clog2(MAX + 1);

    logic [CW-1:0] cnt;

    // Saturates at MAX-1 so a state that lingers never sees the count wrap.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (!done) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign done = (cnt == CW'(MAX - 1));

endmodule

// File: rtl/request_unit.sv
// rtl/request_unit.sv - serialises fetch, optional load/store and commit onto a single-port RAM
module request_unit
    import request_pkg::*;
#(
    parameter int RAM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic [31:0] imemaddr,
    input  logic [31:0] dmmaddr,
    input  logic [31:0] dmmstore,
    input  logic        d_read_req,
    input  logic        d_write_req,
    input  logic [31:0] ramload,
    output logic [31:0] imemload,
    output logic [31:0] dmmload,
    output logic        i_ready,
    output logic        d_ready,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic        Ren,
    output logic        Wen
);

    req_state_t state;
    req_state_t next_state;
    logic       lat_done;
    logic       lat_clear;
    logic       data_write;
    logic       data_visit;

    // Counter restarts whenever the FSM changes state, so every hold begins at zero.
    assign lat_clear = (next_state != state);

    latency_counter #(
        .MAX(RAM_LATENCY)
    ) u_latency (
        .clk  (clk),
        .nRST (nRST),
        .clear(lat_clear),
        .done (lat_done)
    );

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = FETCH;
            FETCH:   if (lat_done) next_state = DECODE;
            DECODE:  next_state = (d_write_req || d_read_req) ? DATA : COMMIT;
            DATA:    if (lat_done) next_state = COMMIT;
            COMMIT:  next_state = FETCH;
            default: next_state = IDLE;
        endcase
    end

    // Write wins over read when the decoder asserts both.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            data_write <= 1'b0;
            data_visit <= 1'b0;
            imemload   <= NOP_INSTR;
            dmmload    <= '0;
        end else begin
            if (state == DECODE) begin
                data_write <= d_write_req;
                data_visit <= d_write_req || d_read_req;
            end
            if (state == FETCH && lat_done) begin
                imemload <= ramload;
            end
            if (state == DATA && lat_done && !data_write) begin
                dmmload <= ramload;
            end
        end
    end

    always_comb begin
        ramaddr  = '0;
        ramstore = '0;
        Ren      = 1'b0;
        Wen      = 1'b0;
        case (state)
            FETCH: begin
                ramaddr = imemaddr & WORD_MASK;
                Ren     = 1'b1;
            end
            DATA: begin
                ramaddr = dmmaddr & WORD_MASK;
                if (data_write) begin
                    Wen      = 1'b1;
                    ramstore = dmmstore;
                end else begin
                    Ren = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign i_ready = (state == COMMIT);
    assign d_ready = (state == COMMIT) && data_visit;

endmodule

// File: tb/tb_request_unit.sv
// tb/tb_request_unit.sv - directed scoreboard bench for request_unit at latency 2 and 1
module tb_request_unit;

    localparam int LAT = 2;

    logic        clk;
    logic        nRST;
    logic [31:0] imemaddr, dmmaddr, dmmstore, ramload;
    logic        d_read_req, d_write_req;
    logic [31:0] imemload, dmmload, ramaddr, ramstore;
    logic        i_ready, d_ready, Ren, Wen;

    logic        nrst1;
    logic [31:0] imemaddr1, ramload1;
    logic [31:0] imemload1, dmmload1, ramaddr1, ramstore1;
    logic        i_ready1, d_ready1, Ren1, Wen1;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] dmm;
        logic        dready;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_dmm;
    int          vectors;
    int          fails;

    request_unit #(.RAM_LATENCY(LAT)) u0 (
        .clk(clk), .nRST(nRST), .imemaddr(imemaddr), .dmmaddr(dmmaddr),
        .dmmstore(dmmstore), .d_read_req(d_read_req), .d_write_req(d_write_req),
        .ramload(ramload), .imemload(imemload), .dmmload(dmmload),
        .i_ready(i_ready), .d_ready(d_ready), .ramaddr(ramaddr),
        .ramstore(ramstore), .Ren(Ren), .Wen(Wen)
    );

    request_unit #(.RAM_LATENCY(1)) u1 (
        .clk(clk), .nRST(nrst1), .imemaddr(imemaddr1), .dmmaddr(32'h0),
        .dmmstore(32'h0), .d_read_req(1'b0), .d_write_req(1'b0),
        .ramload(ramload1), .imemload(imemload1), .dmmload(dmmload1),
        .i_ready(i_ready1), .d_ready(d_ready1), .ramaddr(ramaddr1),
        .ramstore(ramstore1), .Ren(Ren1), .Wen(Wen1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Entered in the cycle before FETCH (IDLE or COMMIT); leaves in COMMIT.
    task automatic run_instr(input logic [31:0] pc, input logic [31:0] instr,
                             input logic rd, input logic wr, input logic [31:0] daddr,
                             input logic [31:0] dstore, input logic [31:0] dval);
        exp_t e;
        logic do_read;
        do_read     = rd && !wr;
        imemaddr    = pc;
        dmmaddr     = daddr;
        dmmstore    = dstore;
        d_read_req  = rd;
        d_write_req = wr;
        ramload     = instr;
        if (do_read) exp_dmm = dval;
        e.instr  = instr;
        e.dmm    = exp_dmm;
        e.dready = rd || wr;
        sb.push_back(e);
        for (int i = 0; i < LAT; i++) begin
            tick();
            check("fetch_ren", Ren, 1);
            check("fetch_wen", Wen, 0);
            check("fetch_addr", ramaddr, {pc[31:2], 2'b00});
            check("fetch_iready", i_ready, 0);
        end
        tick();
        check("decode_ren", Ren, 0);
        check("decode_addr", ramaddr, 0);
        check("decode_imem", imemload, instr);
        ramload = dval;
        if (rd || wr) begin
            for (int i = 0; i < LAT; i++) begin
                tick();
                check("data_addr", ramaddr, {daddr[31:2], 2'b00});
                check("data_ren", Ren, do_read);
                check("data_wen", Wen, wr);
                check("data_store", ramstore, wr ? dstore : 32'h0);
                check("data_iready", i_ready, 0);
            end
        end
        tick();
        check("commit_iready", i_ready, 1);
        check("commit_ren", Ren, 0);
        if (sb.size() == 0) begin
            check("sb_underflow", 0, 1);
        end else begin
            e = sb.pop_front();
            check("commit_dready", d_ready, e.dready);
            check("commit_imem", imemload, e.instr);
            check("commit_dmm", dmmload, e.dmm);
        end
    endtask

    initial begin
        vectors = 0;
        fails   = 0;
        exp_dmm = 32'h0;
        nRST = 1'b0; nrst1 = 1'b0;
        imemaddr = '0; dmmaddr = '0; dmmstore = '0; ramload = '0;
        d_read_req = 1'b0; d_write_req = 1'b0;
        imemaddr1 = '0; ramload1 = '0;
        repeat (2) tick();
        check("rst_imem", imemload, 32'h0000_0013);
        check("rst_dmm", dmmload, 0);
        check("rst_iready", i_ready, 0);
        check("rst_dready", d_ready, 0);
        check("rst_ren", Ren, 0);
        check("rst_wen", Wen, 0);
        check("rst_addr", ramaddr, 0);
        check("rst_store", ramstore, 0);
        nRST = 1'b1;
        check("idle_ren", Ren, 0);

        run_instr(32'h0, 32'h0050_0093, 0, 0, 32'h0, 32'h0, 32'h0);
        run_instr(32'h4, 32'h0460_3083, 1, 0, 32'h46, 32'h0, 32'hDEAD_BEEF);
        run_instr(32'h8, 32'h1000_2023, 0, 1, 32'h100, 32'h1234_5678, 32'hCAFE_F00D);
        run_instr(32'hC, 32'h2000_2023, 1, 1, 32'h200, 32'hA5A5_A5A5, 32'h1111_1111);

        // Store aborted by reset in its second DATA cycle.
        imemaddr = 32'h10; ramload = 32'h3000_2023;
        dmmaddr = 32'h300; dmmstore = 32'h5555_AAAA;
        d_read_req = 1'b0; d_write_req = 1'b1;
        repeat (LAT + 1) tick();
        tick();
        check("abort_wen1", Wen, 1);
        tick();
        check("abort_wen2", Wen, 1);
        nRST = 1'b0;
        #1;
        check("abort_wen_drop", Wen, 0);
        check("abort_addr", ramaddr, 0);
        check("abort_iready", i_ready, 0);
        check("abort_imem", imemload, 32'h0000_0013);
        check("abort_dmm", dmmload, 0);
        exp_dmm = 32'h0;
        tick();
        check("abort_iready_hold", i_ready, 0);
        nRST = 1'b1;
        check("restart_idle_ren", Ren, 0);
        run_instr(32'h0, 32'h0010_0113, 0, 0, 32'h0, 32'h0, 32'h0);

        // Latency-1 instance: back-to-back non-memory instructions.
        tick();
        nrst1 = 1'b1;
        check("l1_idle_ren", Ren1, 0);
        for (int k = 0; k < 4; k++) begin
            imemaddr1 = 32'h40 + 32'(4 * k);
            ramload1  = 32'h0000_0093 + 32'(k << 20);
            tick();
            check("l1_fetch_ren", Ren1, 1);
            check("l1_fetch_addr", ramaddr1, 32'h40 + 32'(4 * k));
            check("l1_fetch_iready", i_ready1, 0);
            tick();
            check("l1_decode_ren", Ren1, 0);
            check("l1_decode_imem", imemload1, 32'h0000_0093 + 32'(k << 20));
            check("l1_decode_iready", i_ready1, 0);
            tick();
            check("l1_commit_iready", i_ready1, 1);
            check("l1_commit_dready", d_ready1, 0);
        end

        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
